seven_seg_scan_controller: RTL and testbench

SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

---
 rtl/seven_seg_scan_controller_pkg.sv | 24 ++
 rtl/seg_decoder_ca.sv | 33 +++
 rtl/seven_seg_scan_controller.sv | 146 ++++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_scan_controller_pkg;

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2
    } scan_state_t;

    // Ticks in the lit/dark part of a digit slot (the dead time is added on top)
    localparam int SLOT_ON_TICKS = 16;

    // Active-low segment bus with everything dark
    localparam logic [7:0] BLANK_SEG = 8'hFF;

    // Width of the decoded {g..a} segment group
    localparam int SEG_W = 7;

    typedef struct packed {
        logic       point;
        logic [3:0] code;
    } digit_entry_t;

endpackage

// File: rtl/seg_decoder_ca.sv
// Hex digit to active-low {g,f,e,d,c,b,a} pattern for a common-anode display.
module seg_decoder_ca
    import seven_seg_scan_controller_pkg::*;
(
    input  logic [3:0]       code,
    output logic [SEG_W-1:0] seg
);

    // Pure lookup, one pattern per hex value
    always_comb begin
        seg = '1;
        case (code)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = '1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed seven-segment scanner with double-buffered digit contents,
// per-slot dead time and tick-based brightness control.
module seven_seg_scan_controller
    import seven_seg_scan_controller_pkg::*;
#(
    parameter int DIGIT_BITS     = 2,
    parameter int PRESCALER_BITS = 16,
    parameter int BLANK_TICKS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DIGIT_BITS-1:0]         wr_addr,
    input  logic [3:0]                    wr_code,
    input  logic                          wr_point,
    input  logic                          commit,
    output logic                          commit_pending,
    input  logic [3:0]                    brightness,
    input  logic                          enable,
    output logic [7:0]                    segments,
    output logic [(1 << DIGIT_BITS)-1:0]  anodes,
    output logic                          frame_start
);

    localparam int DIGITS     = 1 << DIGIT_BITS;
    localparam int SLOT_TICKS = BLANK_TICKS + SLOT_ON_TICKS;
    localparam int PHASE_W    = $clog2(SLOT_TICKS);
    localparam logic [PHASE_W-1:0]    BLANK_END  = PHASE_W'(BLANK_TICKS - 1);
    localparam logic [PHASE_W-1:0]    SLOT_END   = PHASE_W'(SLOT_TICKS - 1);
    localparam logic [DIGIT_BITS-1:0] LAST_DIGIT = DIGIT_BITS'(DIGITS - 1);

    scan_state_t               state_q, state_d;
    logic [PRESCALER_BITS-1:0] presc_q;
    logic [PHASE_W-1:0]        phase_q;
    logic [PHASE_W-1:0]        on_end;
    logic [DIGIT_BITS-1:0]     digit_q;
    logic [3:0]                bright_q;
    logic                      idle_q;
    logic                      pending_q;
    digit_entry_t              back_q  [DIGITS];
    digit_entry_t              front_q [DIGITS];
    logic                      tick, slot_end, frame_wrap, start_edge, swap, wr_fire;
    logic [SEG_W-1:0]          dec_seg;
    logic [7:0]                segments_d;
    logic [DIGITS-1:0]         anodes_d;

    // idle_q marks "held at frame start": after reset or while disabled
    assign tick       = enable & ~idle_q & (&presc_q);
    assign slot_end   = tick & (phase_q == SLOT_END);
    assign frame_wrap = slot_end & (digit_q == LAST_DIGIT);
    assign start_edge = enable & idle_q;
    assign swap       = pending_q & (~enable | idle_q | frame_wrap);
    assign wr_ready   = ~pending_q & ~rst;
    assign wr_fire    = wr_valid & wr_ready;
    assign on_end     = BLANK_END + PHASE_W'(bright_q);
    assign commit_pending = pending_q;

    seg_decoder_ca u_dec (
        .code (front_q[digit_q].code),
        .seg  (dec_seg)
    );

    // Slot sequencing and the next values for the output registers
    always_comb begin
        state_d    = state_q;
        anodes_d   = '1;
        segments_d = BLANK_SEG;
        unique case (state_q)
            S_BLANK: begin
                if (tick && phase_q == BLANK_END)
                    state_d = (bright_q == 4'd0) ? S_OFF : S_ON;
            end
            S_ON: begin
                anodes_d[digit_q] = 1'b0;
                segments_d        = {~front_q[digit_q].point, dec_seg};
                if (tick && phase_q == on_end)
                    state_d = S_OFF;
            end
            S_OFF: begin
                if (slot_end)
                    state_d = S_BLANK;
            end
            default: state_d = S_BLANK;
        endcase
    end

    // Timebase: prescaler, phase within slot, digit index, brightness latch
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_q  <= S_BLANK;
            presc_q  <= '0;
            phase_q  <= '0;
            digit_q  <= '0;
            idle_q   <= 1'b1;
            bright_q <= rst ? 4'd0 : brightness;
        end else if (idle_q) begin
            idle_q   <= 1'b0;
            bright_q <= brightness;
        end else begin
            presc_q <= presc_q + 1'b1;
            state_q <= state_d;
            if (tick)
                phase_q <= slot_end ? '0 : phase_q + 1'b1;
            if (slot_end) begin
                digit_q  <= digit_q + 1'b1;
                bright_q <= brightness;
            end
        end
    end

    // Back-buffer writes, commit latch and front-buffer swap at frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
            pending_q <= 1'b0;
        end else begin
            if (wr_fire)
                back_q[wr_addr] <= '{point: wr_point, code: wr_code};
            if (swap) begin
                for (int i = 0; i < DIGITS; i++)
                    front_q[i] <= back_q[i];
                pending_q <= 1'b0;
            end else if (commit) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Registered display outputs, one clock behind the scan state
    always_ff @(posedge clk) begin
        if (rst) begin
            segments    <= BLANK_SEG;
            anodes      <= '1;
            frame_start <= 1'b0;
        end else begin
            segments    <= segments_d;
            anodes      <= anodes_d;
            frame_start <= start_edge | frame_wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Self-checking bench: time-since-frame-start model plus directed timeline checks.
module tb_seven_seg_scan_controller;

    localparam int NDIG      = 4;
    localparam int BT        = 1;
    localparam int TICK_CLK  = 4;
    localparam int SLOT_CLK  = (BT + 16) * TICK_CLK;
    localparam int FRAME_CLK = SLOT_CLK * NDIG;

    logic       clk = 1'b0;
    logic       rst, wr_valid, wr_ready, wr_point, commit, commit_pending, enable, frame_start;
    logic [1:0] wr_addr;
    logic [3:0] wr_code, brightness;
    logic [7:0] segments;
    logic [3:0] anodes;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seven_seg_scan_controller #(
        .DIGIT_BITS     (2),
        .PRESCALER_BITS (2),
        .BLANK_TICKS    (BT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_code        (wr_code),
        .wr_point       (wr_point),
        .commit         (commit),
        .commit_pending (commit_pending),
        .brightness     (brightness),
        .enable         (enable),
        .segments       (segments),
        .anodes         (anodes),
        .frame_start    (frame_start)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] font_of(input logic [3:0] c);
        case (c)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    // Reference model: position in the frame counted in clocks
    bit         m_valid = 1'b0;
    bit         m_run, m_pending;
    int         m_t, m_bright;
    logic [3:0] m_fcode [NDIG];
    logic [3:0] m_bcode [NDIG];
    logic       m_fpt   [NDIG];
    logic       m_bpt   [NDIG];
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic       e_fs;

    always @(posedge clk) begin : model_b
        int slot, tk;
        bit boundary, start, swap;
        if (rst) begin
            m_valid = 1'b1; m_run = 1'b0; m_t = 0; m_bright = 0; m_pending = 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                m_fcode[i] = 4'h0; m_bcode[i] = 4'h0; m_fpt[i] = 1'b0; m_bpt[i] = 1'b0;
            end
            e_seg = 8'hFF; e_an = 4'hF; e_fs = 1'b0;
        end else begin
            e_seg = 8'hFF; e_an = 4'hF;
            if (m_run) begin
                slot = m_t / SLOT_CLK;
                tk   = (m_t % SLOT_CLK) / TICK_CLK;
                if (tk >= BT && tk < BT + m_bright) begin
                    e_an[slot] = 1'b0;
                    e_seg = m_fpt[slot] ? (font_of(m_fcode[slot]) & 8'h7F) : font_of(m_fcode[slot]);
                end
            end
            start    = !m_run && enable;
            boundary = m_run && enable && (m_t == FRAME_CLK - 1);
            e_fs     = start || boundary;
            swap     = m_pending && (!enable || start || boundary);
            if (wr_valid && !m_pending) begin
                m_bcode[wr_addr] = wr_code;
                m_bpt[wr_addr]   = wr_point;
            end
            if (swap) begin
                for (int i = 0; i < NDIG; i++) begin
                    m_fcode[i] = m_bcode[i]; m_fpt[i] = m_bpt[i];
                end
                m_pending = 1'b0;
            end else if (commit) begin
                m_pending = 1'b1;
            end
            if (!enable) begin
                m_run = 1'b0; m_t = 0; m_bright = int'(brightness);
            end else if (!m_run) begin
                m_run = 1'b1; m_t = 0; m_bright = int'(brightness);
            end else begin
                m_t = (m_t + 1) % FRAME_CLK;
                if (m_t % SLOT_CLK == 0) m_bright = int'(brightness);
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("segments", 32'(segments), 32'(e_seg));
            chk("anodes", 32'(anodes), 32'(e_an));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
            chk("commit_pending", 32'(commit_pending), 32'(m_pending));
            chk("wr_ready", 32'(wr_ready), 32'(!m_pending && !rst));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) step();
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (frame_start !== 1'b1 && n < 400);
        chk("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] c, input logic p, input logic cm);
        wr_valid = 1'b1; wr_addr = a; wr_code = c; wr_point = p; commit = cm;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main_b
        int   n, cnt0, cnt2, cntlit;
        logic acc;
        rst = 1'b1; enable = 1'b1; brightness = 4'd15; commit = 1'b0;
        wr_valid = 1'b0; wr_addr = 2'd0; wr_code = 4'd0; wr_point = 1'b0;
        adv(3);
        chk("rst_segments", 32'(segments), 32'hFF);
        chk("rst_anodes", 32'(anodes), 32'hF);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_commit_pending", 32'(commit_pending), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);

        // Basic scan timeline at full brightness
        rst = 1'b0;
        wait_fs(n);
        chk("fs_latency_after_reset", 32'(n), 32'd1);
        adv(4);  chk("blank_anodes_f4", 32'(anodes), 32'hF);
        adv(1);  chk("on_anodes_f5", 32'(anodes), 32'hE);
                 chk("on_segments_f5", 32'(segments), 32'hC0);
        adv(59); chk("on_anodes_f64", 32'(anodes), 32'hE);
        adv(1);  chk("off_anodes_f65", 32'(anodes), 32'hF);
        adv(8);  chk("digit1_anodes_f73", 32'(anodes), 32'hD);
        wait_fs(n);
        chk("frame_period", 32'(n + 73), 32'd272);

        // Write + commit held off until the frame boundary
        write(2'd1, 4'd5, 1'b1, 1'b1);
        step();
        wr_valid = 1'b0; commit = 1'b0;
        chk("commit_pending_set", 32'(commit_pending), 32'd1);
        chk("wr_ready_low_pending", 32'(wr_ready), 32'd0);
        wait_fs(n);
        chk("commit_pending_cleared", 32'(commit_pending), 32'd0);
        chk("wr_ready_after_swap", 32'(wr_ready), 32'd1);
        adv(73);
        chk("digit1_code5_anodes", 32'(anodes), 32'hD);
        chk("digit1_code5_point", 32'(segments), 32'h12);

        // Brightness 0 then 4
        brightness = 4'd0;
        wait_fs(n);
        cntlit = 0;
        for (int k = 0; k < FRAME_CLK; k++) begin
            step();
            if (anodes !== 4'hF) cntlit++;
        end
        chk("dark_frame_lit_cycles", 32'(cntlit), 32'd0);
        brightness = 4'd4;
        wait_fs(n);
        cnt0 = 0; cnt2 = 0;
        for (int k = 0; k < FRAME_CLK; k++) begin
            step();
            if (anodes === 4'hE) cnt0++;
            if (anodes === 4'hB) cnt2++;
        end
        chk("bright4_digit0_cycles", 32'(cnt0), 32'd16);
        chk("bright4_digit2_cycles", 32'(cnt2), 32'd16);

        // Write held while pending: accepted after swap, shown only after next commit
        brightness = 4'd15;
        write(2'd1, 4'd9, 1'b0, 1'b1);
        step();
        commit = 1'b0;
        write(2'd2, 4'd3, 1'b0, 1'b0);
        chk("held_write_stalled", 32'(wr_ready), 32'd0);
        wait_fs(n);
        chk("held_write_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        chk("held_write_no_commit", 32'(commit_pending), 32'd0);
        adv(72);
        chk("digit1_code9", 32'(segments), 32'h90);
        adv(68);
        chk("digit2_still_old_anodes", 32'(anodes), 32'hB);
        chk("digit2_still_old", 32'(segments), 32'hC0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        wait_fs(n);
        adv(141);
        chk("digit2_code3", 32'(segments), 32'hB0);

        // Reset during S_ON with a commit pending
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("pending_before_rst", 32'(commit_pending), 32'd1);
        adv(3);
        rst = 1'b1;
        step();
        chk("midslot_rst_anodes", 32'(anodes), 32'hF);
        chk("midslot_rst_segments", 32'(segments), 32'hFF);
        chk("midslot_rst_pending", 32'(commit_pending), 32'd0);
        rst = 1'b0;
        wait_fs(n);
        chk("fs_latency_after_rst", 32'(n), 32'd1);
        adv(5);
        for (int d = 0; d < NDIG; d++) begin
            if (d != 0) adv(SLOT_CLK);
            chk("post_rst_anodes", 32'(anodes), 32'(4'hF & ~(4'h1 << d)));
            chk("post_rst_segments", 32'(segments), 32'hC0);
        end

        // Enable dropped mid-slot with a pending commit
        wait_fs(n);
        adv(20);
        write(2'd0, 4'd7, 1'b1, 1'b1);
        step();
        wr_valid = 1'b0; commit = 1'b0;
        chk("pending_before_disable", 32'(commit_pending), 32'd1);
        enable = 1'b0;
        step();
        chk("disable_pending_cleared", 32'(commit_pending), 32'd0);
        chk("disable_anodes_lag", 32'(anodes), 32'hE);
        step();
        chk("disable_anodes_off", 32'(anodes), 32'hF);
        adv(5);
        chk("disabled_no_frame_start", 32'(frame_start), 32'd0);
        enable = 1'b1;
        step();
        chk("enable_frame_start", 32'(frame_start), 32'd1);
        adv(5);
        chk("enable_digit0_anodes", 32'(anodes), 32'hE);
        chk("enable_digit0_code7", 32'(segments), 32'h78);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            acc = wr_valid && wr_ready;
            step();
            commit = 1'b0;
            if (acc || !wr_valid) begin
                wr_valid = 1'b0;
                if ($urandom_range(0, 5) == 0)
                    write(2'($urandom), 4'($urandom), 1'($urandom), 1'b0);
            end
            if ($urandom_range(0, 39) == 0) commit = 1'b1;
            if ($urandom_range(0, 149) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            rst = ($urandom_range(0, 1499) == 0);
        end
        rst = 1'b0;
        adv(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
